// File: rtl/tensor_stream_builder.sv
// rtl/tensor_stream_builder.sv - packs a scalar element stream into ROWSxCOLS tensors
// Two ping-pong banks let one tensor fill while the other is held for the consumer.
module tensor_stream_builder #(
  parameter int WIDTH = 17,
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  localparam int FCW  = $clog2(ROWS*COLS+1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [WIDTH-1:0]                       s_data,
  input  logic                                   flush,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   m_tensor,
  output logic [FCW-1:0]                         fill_count
);

  localparam int N  = ROWS*COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] tensor_t;

  tensor_t        bank_q [2];
  logic [1:0]     full_q, full_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [FCW-1:0] fill_q, fill_d;

  logic do_accept;
  logic do_release;
  logic last_elem;

  assign s_ready    = !rst && !flush && !full_q[wr_bank_q];
  assign m_valid    = full_q[rd_bank_q];
  assign m_tensor   = m_valid ? bank_q[rd_bank_q] : '0;
  assign fill_count = fill_q;

  assign do_accept  = s_valid && s_ready;
  assign do_release = m_valid && m_ready;
  assign last_elem  = (fill_q == FCW'(N-1));

  // Accept and release never touch the same bank: accept needs it EMPTY, release needs it FULL.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_d     = row_q;
    col_d     = col_q;
    fill_d    = fill_q;
    if (flush) begin
      row_d  = '0;
      col_d  = '0;
      fill_d = '0;
    end else if (do_accept) begin
      if (last_elem) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        row_d             = '0;
        col_d             = '0;
        fill_d            = '0;
      end else begin
        fill_d = fill_q + 1'b1;
        if (col_q == CW'(COLS-1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
    if (do_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      fill_q    <= '0;
    end else begin
      if (do_accept) begin
        bank_q[wr_bank_q][row_q][col_q] <= s_data;
      end
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: tb/tb_tensor_stream_builder.sv
// tb/tb_tensor_stream_builder.sv - self-checking bench for tensor_stream_builder
// Reference model: a queue of completed tensors (at most two) plus a list of partial elements.
module tb_tensor_stream_builder;

  localparam int W = 17;
  localparam int R = 3;
  localparam int C = 3;
  localparam int N = R*C;

  typedef logic [R-1:0][C-1:0][W-1:0] tens_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, s_valid, s_ready, flush, m_valid, m_ready;
  logic [W-1:0] s_data;
  tens_t        m_tensor;
  logic [3:0]   fill_count;

  logic                 rst2, s_valid2, s_ready2, flush2, m_valid2, m_ready2;
  logic [7:0]           s_data2;
  logic [1:0][3:0][7:0] m_tensor2;
  logic [3:0]           fill_count2;

  tensor_stream_builder #(.WIDTH(W), .ROWS(R), .COLS(C)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_tensor(m_tensor),
    .fill_count(fill_count)
  );

  tensor_stream_builder #(.WIDTH(8), .ROWS(2), .COLS(4)) u_dut2 (
    .clk(clk), .rst(rst2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .flush(flush2), .m_valid(m_valid2), .m_ready(m_ready2), .m_tensor(m_tensor2),
    .fill_count(fill_count2)
  );

  int n_cmp = 0;
  int n_err = 0;

  tens_t        done_q[$];
  logic [W-1:0] part_q[$];
  logic         last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_t(input string tag, input tens_t obs, input tens_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic mr,
                      input logic fl, input logic r);
    logic  e_ready, e_valid;
    tens_t e_t, t;
    @(negedge clk);
    s_valid = v; s_data = d; m_ready = mr; flush = fl; rst = r;
    #1;
    e_ready = !r && !fl && (done_q.size() < 2);
    e_valid = (done_q.size() > 0);
    e_t     = e_valid ? done_q[0] : '0;
    chk("s_ready", 64'(s_ready), 64'(e_ready));
    chk("m_valid", 64'(m_valid), 64'(e_valid));
    chk_t("m_tensor", m_tensor, e_t);
    chk("fill_count", 64'(fill_count), 64'(part_q.size()));
    last_acc = v && e_ready;
    if (r) begin
      done_q.delete();
      part_q.delete();
    end else begin
      if (e_valid && mr) void'(done_q.pop_front());
      if (fl) part_q.delete();
      else if (last_acc) begin
        part_q.push_back(d);
        if (part_q.size() == N) begin
          for (int i = 0; i < N; i++) t[i/C][i%C] = part_q[i];
          done_q.push_back(t);
          part_q.delete();
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic mr);
    int k;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 50) begin
      step(1'b1, d, mr, 1'b0, 1'b0);
      k++;
    end
    if (!last_acc) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout observed=stalled expected=accepted data=%0d", d);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b1;
    rst2 = 1'b1; s_valid2 = 1'b0; s_data2 = '0; flush2 = 1'b0; m_ready2 = 1'b0;
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);

    // Reset state
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-to-back 1..9 with m_ready=1
    for (int i = 1; i <= N; i++) send(W'(i), 1'b1);
    #1;
    chk("b2b_m_valid", 64'(m_valid), 64'd1);
    chk("b2b_t00", 64'(m_tensor[0][0]), 64'd1);
    chk("b2b_t02", 64'(m_tensor[0][2]), 64'd3);
    chk("b2b_t10", 64'(m_tensor[1][0]), 64'd4);
    chk("b2b_t22", 64'(m_tensor[2][2]), 64'd9);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("b2b_one_cycle", 64'(m_valid), 64'd0);

    // Backpressure: both banks fill, element 19 stalls
    for (int i = 1; i <= 18; i++) send(W'(i), 1'b0);
    #1;
    chk("bp_both_full_ready", 64'(s_ready), 64'd0);
    repeat (3) step(1'b1, W'(19), 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_hold_t00", 64'(m_tensor[0][0]), 64'd1);
    send(W'(19), 1'b1);
    #1;
    chk("bp_after19_fill", 64'(fill_count), 64'd1);
    for (int i = 20; i <= 27; i++) send(W'(i), 1'b0);
    #1;
    chk("bp_t00_is_19", 64'(m_tensor[0][0]), 64'd19);
    chk("bp_t22_is_27", 64'(m_tensor[2][2]), 64'd27);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush mid-fill
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b1);
    #1;
    chk("flush_fill_before", 64'(fill_count), 64'd4);
    step(1'b1, W'(99), 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_fill_after", 64'(fill_count), 64'd0);
    for (int i = 20; i <= 28; i++) send(W'(i), 1'b0);
    #1;
    chk("flush_t00", 64'(m_tensor[0][0]), 64'd20);
    chk("flush_t22", 64'(m_tensor[2][2]), 64'd28);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset with one full bank and a partial one
    for (int i = 1; i <= 12; i++) send(W'(i), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk_t("rst_tensor", m_tensor, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end

    // 2x4 geometry
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      s_valid2 = 1'b1;
      s_data2  = 8'(i);
      #1;
      chk("g24_s_ready", 64'(s_ready2), 64'd1);
    end
    @(negedge clk);
    s_valid2 = 1'b0;
    #1;
    chk("g24_m_valid", 64'(m_valid2), 64'd1);
    chk("g24_t03", 64'(m_tensor2[0][3]), 64'd4);
    chk("g24_t10", 64'(m_tensor2[1][0]), 64'd5);
    chk("g24_t13", 64'(m_tensor2[1][3]), 64'd8);
    chk("g24_fill", 64'(fill_count2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tensor_stream_builder.md
TENSOR_STREAM_BUILDER -- requirements
Module: tensor_stream_builder

Interface
REQ-001 Parameter WIDTH, default 17, SHALL set the element bit width.
REQ-002 Parameter ROWS, default 3, SHALL set the tensor row count (>=1).
REQ-003 Parameter COLS, default 3, SHALL set the tensor column count (>=1).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-006 Port s_valid, input, 1 bit, SHALL indicate that s_data holds a valid element.
REQ-007 Port s_ready, output, 1 bit, SHALL indicate that the block can accept an element this cycle.
REQ-008 Port s_data, input, WIDTH bits, SHALL carry the input element.
REQ-009 Port flush, input, 1 bit, SHALL discard the partially filled tensor.
REQ-010 Port m_valid, output, 1 bit, SHALL indicate that m_tensor holds a complete tensor.
REQ-011 Port m_ready, input, 1 bit, SHALL indicate that the consumer accepts the tensor.
REQ-012 Port m_tensor, output, WIDTH bits x [ROWS][COLS], SHALL be the presented tensor.
REQ-013 Port fill_count, output, $clog2(ROWS*COLS+1) bits, SHALL be the number of elements in the partial tensor.

Function
REQ-014 Storage SHALL be two tensor banks (bank0, bank1), each ROWS x COLS x WIDTH, with per-bank state EMPTY/FULL, a write-bank pointer wr_bank and a read-bank pointer rd_bank.
REQ-015 An element SHALL be accepted only on a cycle with s_valid=1, s_ready=1 and flush=0.
REQ-016 An accepted element SHALL be written to bank[wr_bank][row][col], in row-major order: col increments; at COLS-1, col wraps to 0 and row increments.
REQ-017 On acceptance of element ROWS*COLS, bank[wr_bank] SHALL go FULL, row/col/fill_count SHALL return to 0, and wr_bank SHALL toggle.
REQ-018 s_ready SHALL be 1 iff bank[wr_bank] is EMPTY and rst=0 (combinational from state; independent of s_valid).
REQ-019 m_valid SHALL be 1 iff bank[rd_bank] is FULL; m_tensor SHALL equal bank[rd_bank] when m_valid=1, otherwise all zeros.
REQ-020 On m_valid=1 and m_ready=1, bank[rd_bank] SHALL go EMPTY and rd_bank SHALL toggle; m_valid/m_tensor SHALL stay stable while m_valid=1 and m_ready=0.
REQ-021 Latency: m_valid SHALL rise in the cycle after the final element is accepted.
REQ-022 Completion of one bank and release of the other in the same cycle SHALL both take effect.
REQ-023 With m_ready held 1, the block SHALL sustain 1 element/cycle with no s_ready gaps.
REQ-024 With both banks FULL, s_ready SHALL be 0; a release SHALL make s_ready 1 on the next cycle.
REQ-025 flush=1 SHALL force s_ready=0, reset row/col/fill_count to 0, and leave FULL banks, pointers and m_valid unaffected; the partial bank's contents are overwritten by the next fill.
REQ-026 fill_count SHALL equal the accepted elements of the current partial tensor (0..ROWS*COLS-1).

Reset
REQ-027 While rst=1 at a clock edge, all bank elements SHALL clear to 0, both banks go EMPTY, wr_bank=rd_bank=0, row=col=fill_count=0.
REQ-028 After reset, outputs SHALL be s_ready=1, m_valid=0, m_tensor all zeros, fill_count=0; reset mid-fill or with m_valid=1 SHALL discard all data.
REQ-029 While rst=1, s_ready SHALL be 0 and no element SHALL be accepted.

Verification
REQ-030 Reset: hold rst 2 cycles -> s_ready=1, m_valid=0, m_tensor all 0, fill_count=0.
REQ-031 Defaults, m_ready=1, stream 1..9 back-to-back -> m_valid high exactly one cycle, one cycle after element 9; tensor[0][0]=1, [0][2]=3, [1][0]=4, [2][2]=9.
REQ-032 m_ready=0, stream 1..19 -> s_ready drops after element 18; element 19 stalls; raising m_ready yields tensor 1..9, then 10..18, then s_ready=1 and element 19 lands at [0][0].
REQ-033 Accept 1..4, pulse flush (s_valid=1 same cycle), stream 20..28 -> fill_count 4 then 0; output tensor [0][0]=20, [2][2]=28; no element dropped apart from the flush cycle's.
REQ-034 Fill bank0 (m_ready=0), accept 3 elements into bank1, assert rst -> next cycle m_valid=0, fill_count=0, m_tensor all 0.
REQ-035 ROWS=2, COLS=4, stream 1..8 -> tensor[0][3]=4, [1][0]=5, [1][3]=8; fill_count width 4 bits.
